// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   BAUD_DIV_DEF   : default clk cycles per bit (50 MHz / 19200 baud)
//   FIFO_DEPTH_DEF : default transmit FIFO depth
//   FRAME_BITS     : 8N1 frame length (start + 8 data + stop)
//   tx_state_t     : transmitter FSM states
//   frame_of()     : builds the LSB-first frame {stop, data, start}
package uart_pkg;

    localparam int unsigned BAUD_DIV_DEF   = 2604;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned FRAME_BITS     = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } tx_state_t;

    function automatic logic [FRAME_BITS-1:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// Host-side handshake of the buffered UART transmitter.
//   trmt      : push strobe
//   tx_data   : byte sampled on the trmt cycle
//   clr_ovf   : clears the sticky overflow flag
//   tx_done   : last queued frame finished (level)
//   fifo_full : transmit FIFO full
//   ovf       : sticky, a push was dropped because the FIFO was full
// master = host logic, slave = transmitter.
interface uart_tx_buf_if;

    logic       trmt;
    logic [7:0] tx_data;
    logic       clr_ovf;
    logic       tx_done;
    logic       fifo_full;
    logic       ovf;

    modport master (
        output trmt, tx_data, clr_ovf,
        input  tx_done, fifo_full, ovf
    );

    modport slave (
        input  trmt, tx_data, clr_ovf,
        output tx_done, fifo_full, ovf
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO for the UART transmitter.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en      : write wr_data (ignored while full)
//   rd_en      : pop the head entry (ignored while empty)
//   rd_data    : current head entry, valid while !empty
//   full/empty : occupancy flags, derived from the registered pointers
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_wr;
    logic             w_do_rd;

    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_wr = wr_en && !full;
    assign w_do_rd = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter (start 0, 8 data LSB-first, stop 1).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : host handshake (trmt/tx_data/clr_ovf in, tx_done/fifo_full/ovf out)
//   TX         : serial line, idle high, bit 0 of the shift register flop
// Bytes are queued in uart_tx_fifo and serialized back-to-back; the LOAD
// state between frames stretches the stop bit by one clock.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = BAUD_DIV_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_buf_if.slave  bus,
    output logic          TX
);

    localparam int unsigned     BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [3:0]      LAST_BIT  = 4'(FRAME_BITS - 1);

    tx_state_t               r_state;
    logic [BW-1:0]           r_baud_cnt;
    logic [3:0]              r_bit_cnt;
    logic [FRAME_BITS-1:0]   r_shift;
    logic                    r_tx_done;
    logic                    r_ovf;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_wr_en;
    logic                    w_rd_en;
    logic [7:0]              w_rd_data;

    // Full is judged on the registered pointers, so a push in the same cycle
    // as a pop from a full FIFO is still rejected.
    assign w_wr_en = bus.trmt && !w_full;
    assign w_rd_en = (r_state == LOAD);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr_en),
        .wr_data (bus.tx_data),
        .rd_en   (w_rd_en),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty)
    );

    // The shift register is filled with ones from the top, so once a frame
    // has shifted out it rests all-ones and TX idles high without a mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '1;
            r_tx_done  <= 1'b0;
        end else begin
            if (w_wr_en) r_tx_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) r_state <= LOAD;
                end
                LOAD: begin
                    r_shift    <= frame_of(w_rd_data);
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_state    <= SHIFT;
                end
                SHIFT: begin
                    if (r_baud_cnt == BAUD_LAST) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= r_bit_cnt + 4'd1;
                        r_shift    <= {1'b1, r_shift[FRAME_BITS-1:1]};
                        // Stop bit ends here: chain the next frame or finish.
                        if (r_bit_cnt == LAST_BIT) begin
                            if (!w_empty) begin
                                r_state <= LOAD;
                            end else begin
                                r_state <= IDLE;
                                // An accepted push this cycle keeps tx_done low.
                                if (!w_wr_en) r_tx_done <= 1'b1;
                            end
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_ovf <= 1'b0;
        else if (bus.trmt && w_full)     r_ovf <= 1'b1;
        else if (bus.clr_ovf)            r_ovf <= 1'b0;
    end

    assign TX            = r_shift[0];
    assign bus.tx_done   = r_tx_done;
    assign bus.fifo_full = w_full;
    assign bus.ovf       = r_ovf;

endmodule
